// File: rtl/histo_cdf_reader_pkg.sv
// Shared types and constants for the histogram CDF readout path.
// Defaults target a 640x480 frame with 256 gray levels.
package histo_cdf_reader_pkg;

   typedef enum logic [2:0] {IDLE, READ, DRAIN, CLEAR, DONE} stateT;

   localparam int DEF_ADDR_WIDTH  = 8;
   localparam int DEF_NBINS       = 2 ** DEF_ADDR_WIDTH;
   localparam int DEF_SCALE_MUL   = 870;
   localparam int DEF_SCALE_SHIFT = 20;

   // One extra bit holds the carry so a saturating add can detect overflow.
   function automatic int satAddWidth(input int width);
      return width + 1;
   endfunction

endpackage

// File: rtl/histo_lut_scale.sv
// Registered multiply-shift-clamp turning a CDF value into an equalised gray level.
// The parent feeds the next CDF value so oLut lines up with its own registered oCdf.
module histo_lut_scale
   import histo_cdf_reader_pkg::*;
#(
   parameter int DATA_WIDTH  = 20,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int SCALE_WIDTH = 10,
   parameter int SCALE_MUL   = DEF_SCALE_MUL,
   parameter int SCALE_SHIFT = DEF_SCALE_SHIFT
)
(
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic                  iEn,
   input  logic [DATA_WIDTH-1:0] iCdf,
   output logic [ADDR_WIDTH-1:0] oLut
);

   localparam int PROD_WIDTH = DATA_WIDTH + SCALE_WIDTH;
   localparam logic [PROD_WIDTH-1:0] LUT_MAX = PROD_WIDTH'((2 ** ADDR_WIDTH) - 1);

   logic [PROD_WIDTH-1:0] prod;
   logic [PROD_WIDTH-1:0] scaled;

   always_comb begin
      prod   = PROD_WIDTH'(iCdf) * PROD_WIDTH'(SCALE_MUL);
      scaled = prod >> SCALE_SHIFT;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         oLut <= '0;
      end else if (iEn) begin
         oLut <= (scaled > LUT_MAX) ? '1 : scaled[ADDR_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/histo_cdf_reader.sv
// Sweeps the histogram read port, streams count/CDF/LUT per bin, then clears the histogram.
// Result timing is carried by a valid/index pipe matching the read-port latency.
module histo_cdf_reader
   import histo_cdf_reader_pkg::*;
#(
   parameter int DATA_WIDTH  = 20,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int RD_LATENCY  = 2,
   parameter int SCALE_MUL   = DEF_SCALE_MUL,
   parameter int SCALE_WIDTH = 10,
   parameter int SCALE_SHIFT = DEF_SCALE_SHIFT
)
(
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic                  iStart,
   output logic [ADDR_WIDTH-1:0] oGray,
   input  logic [DATA_WIDTH-1:0] iGrayHisto,
   output logic                  oClear,
   output logic                  oBusy,
   output logic                  oValid,
   output logic [ADDR_WIDTH-1:0] oBin,
   output logic [DATA_WIDTH-1:0] oCount,
   output logic [DATA_WIDTH-1:0] oCdf,
   output logic [ADDR_WIDTH-1:0] oLut,
   output logic                  oDone
);

   localparam int NBINS     = 2 ** ADDR_WIDTH;
   localparam int SUM_WIDTH = satAddWidth(DATA_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NBINS - 1);
   localparam logic [ADDR_WIDTH-1:0] DRAIN_LAST = ADDR_WIDTH'(RD_LATENCY);

   stateT                 state, stateNext;
   logic [ADDR_WIDTH-1:0] addr, addrNext;
   logic                  issue, cdfClr, resultEn;
   logic [RD_LATENCY-1:0] pipeValid;
   logic [ADDR_WIDTH-1:0] pipeIdx [RD_LATENCY];
   logic [DATA_WIDTH-1:0] cdfAcc, cdfSum;
   logic [SUM_WIDTH-1:0]  sumWide;

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state <= IDLE;
         addr  <= '0;
      end else begin
         state <= stateNext;
         addr  <= addrNext;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      stateNext = state;
      addrNext  = addr;
      cdfClr    = 1'b0;
      issue     = 1'b0;
      oGray     = '0;
      oClear    = 1'b0;
      oBusy     = 1'b0;
      oDone     = 1'b0;
      case (state)
         IDLE: begin
            if (iStart) begin
               stateNext = READ;
               addrNext  = '0;
               cdfClr    = 1'b1;
            end
         end
         READ: begin
            oBusy    = 1'b1;
            oGray    = addr;
            issue    = 1'b1;
            addrNext = addr + 1'b1;
            if (addr == LAST_ADDR) begin
               stateNext = DRAIN;
               addrNext  = '0;
            end
         end
         DRAIN: begin
            // Lets the final read emerge from the port and the result register.
            oBusy    = 1'b1;
            addrNext = addr + 1'b1;
            if (addr == DRAIN_LAST) begin
               stateNext = CLEAR;
               addrNext  = '0;
            end
         end
         CLEAR: begin
            oBusy    = 1'b1;
            oClear   = 1'b1;
            addrNext = addr + 1'b1;
            if (addr == LAST_ADDR) begin
               stateNext = DONE;
               addrNext  = '0;
            end
         end
         DONE: begin
            oDone     = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // NOTE: the index pipe is a handful of flops, not a RAM, so resetting it costs nothing and keeps it X-free.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         pipeValid <= '0;
         for (int i = 0; i < RD_LATENCY; i++) pipeIdx[i] <= '0;
      end else begin
         pipeValid[0] <= issue;
         pipeIdx[0]   <= addr;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipeValid[i] <= pipeValid[i-1];
            pipeIdx[i]   <= pipeIdx[i-1];
         end
      end
   end

   assign resultEn = pipeValid[RD_LATENCY-1];
   assign sumWide  = SUM_WIDTH'(cdfAcc) + SUM_WIDTH'(iGrayHisto);
   assign cdfSum   = sumWide[SUM_WIDTH-1] ? '1 : sumWide[DATA_WIDTH-1:0];

   // The accumulator is kept apart from oCdf so the output can hold between readouts.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         cdfAcc <= '0;
         oValid <= 1'b0;
         oBin   <= '0;
         oCount <= '0;
         oCdf   <= '0;
      end else begin
         oValid <= resultEn;
         if (cdfClr) begin
            cdfAcc <= '0;
         end else if (resultEn) begin
            cdfAcc <= cdfSum;
         end
         if (resultEn) begin
            oBin   <= pipeIdx[RD_LATENCY-1];
            oCount <= iGrayHisto;
            oCdf   <= cdfSum;
         end
      end
   end

   histo_lut_scale #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .SCALE_WIDTH(SCALE_WIDTH),
      .SCALE_MUL  (SCALE_MUL),
      .SCALE_SHIFT(SCALE_SHIFT)
   ) uLutScale (
      .iClk(iClk),
      .iRst(iRst),
      .iEn (resultEn),
      .iCdf(cdfSum),
      .oLut(oLut)
   );

endmodule

// File: tb/tb_histo_cdf_reader.sv
// Bench for histo_cdf_reader: latency-2 histogram memory model plus a bin-level CDF/LUT reference.
// Each readout is checked cycle by cycle against the expected phase schedule.
module tb_histo_cdf_reader;

  localparam int DW      = 20;
  localparam int AW      = 8;
  localparam int LAT     = 2;
  localparam int NB      = 1 << AW;
  localparam int SCALE   = 870;
  localparam int SHIFT   = 20;
  localparam longint CDF_MAX = (longint'(1) << DW) - 1;

  // Cycle schedule relative to the first READ cycle.
  localparam int VALID_FIRST = LAT + 1;
  localparam int VALID_LAST  = NB + LAT;
  localparam int CLEAR_FIRST = NB + LAT + 1;
  localparam int CLEAR_LAST  = CLEAR_FIRST + NB - 1;
  localparam int DONE_CYC    = CLEAR_LAST + 1;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iStart;
  logic [AW-1:0] oGray;
  logic [DW-1:0] iGrayHisto;
  logic          oClear, oBusy, oValid, oDone;
  logic [AW-1:0] oBin, oLut;
  logic [DW-1:0] oCount, oCdf;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] histo [NB];
  logic [DW-1:0] rd1, rd2;
  longint        expCdf [NB];
  longint        expLut [NB];

  always #5 iClk = ~iClk;

  always @(posedge iClk) begin
    rd1 <= histo[oGray];
    rd2 <= rd1;
  end
  assign iGrayHisto = rd2;

  histo_cdf_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RD_LATENCY (LAT),
    .SCALE_MUL  (SCALE),
    .SCALE_WIDTH(10),
    .SCALE_SHIFT(SHIFT)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iStart    (iStart),
    .oGray     (oGray),
    .iGrayHisto(iGrayHisto),
    .oClear    (oClear),
    .oBusy     (oBusy),
    .oValid    (oValid),
    .oBin      (oBin),
    .oCount    (oCount),
    .oCdf      (oCdf),
    .oLut      (oLut),
    .oDone     (oDone)
  );

  task automatic check(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  // Reference: running sum saturating at full scale, LUT = clamp(cdf*SCALE >> SHIFT).
  task automatic build_model();
    longint cdf = 0;
    longint lut;
    for (int k = 0; k < NB; k++) begin
      cdf = cdf + longint'(histo[k]);
      if (cdf > CDF_MAX) cdf = CDF_MAX;
      lut = (cdf * SCALE) >> SHIFT;
      expCdf[k] = cdf;
      expLut[k] = (lut > NB - 1) ? NB - 1 : lut;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({oGray, oClear, oBusy, oValid, oBin, oCount, oCdf, oLut, oDone} === '0,
          $sformatf("%s: gray=%0d clear=%b busy=%b valid=%b bin=%0d count=%0d cdf=%0d lut=%0d done=%b, required all 0",
                    tag, oGray, oClear, oBusy, oValid, oBin, oCount, oCdf, oLut, oDone));
  endtask

  // Full readout; iStart is re-pulsed at cycles pokeA/B/C (-1 = never) to test it is ignored.
  task automatic run_readout(input string tag, input int pokeA, input int pokeB, input int pokeC,
                             output logic [DW-1:0] lastCdf, output logic [AW-1:0] lastLut);
    logic [3:0]    expCtl;
    logic [AW-1:0] expGray;
    int            k;
    build_model();
    @(negedge iClk);
    iStart = 1'b1;
    for (int cyc = 0; cyc <= DONE_CYC + 2; cyc++) begin
      @(negedge iClk);
      iStart = (cyc == pokeA || cyc == pokeB || cyc == pokeC);
      expCtl = {cyc <= CLEAR_LAST,
                cyc >= CLEAR_FIRST && cyc <= CLEAR_LAST,
                cyc == DONE_CYC,
                cyc >= VALID_FIRST && cyc <= VALID_LAST};
      expGray = (cyc < NB) ? AW'(cyc) : '0;
      check({oBusy, oClear, oDone, oValid} === expCtl,
            $sformatf("%s ctrl cyc=%0d: busy/clear/done/valid=%b required %b",
                      tag, cyc, {oBusy, oClear, oDone, oValid}, expCtl));
      check(oGray === expGray,
            $sformatf("%s gray cyc=%0d: got %0d required %0d", tag, cyc, oGray, expGray));
      if (expCtl[0]) begin
        k = cyc - VALID_FIRST;
        check(oBin === AW'(k) && oCount === histo[k] && oCdf === DW'(expCdf[k]) && oLut === AW'(expLut[k]),
              $sformatf("%s bin %0d: bin=%0d count=%0d cdf=%0d lut=%0d required bin=%0d count=%0d cdf=%0d lut=%0d",
                        tag, k, oBin, oCount, oCdf, oLut, k, histo[k], expCdf[k], expLut[k]));
      end else if (cyc > VALID_LAST) begin
        check(oBin === AW'(NB - 1) && oCount === histo[NB-1] && oCdf === DW'(expCdf[NB-1]) && oLut === AW'(expLut[NB-1]),
              $sformatf("%s hold cyc=%0d: bin=%0d count=%0d cdf=%0d lut=%0d required bin=%0d count=%0d cdf=%0d lut=%0d",
                        tag, cyc, oBin, oCount, oCdf, oLut, NB - 1, histo[NB-1], expCdf[NB-1], expLut[NB-1]));
      end
    end
    iStart  = 1'b0;
    lastCdf = oCdf;
    lastLut = oLut;
  endtask

  task automatic check_final(input string tag, input logic [DW-1:0] gotCdf, input logic [AW-1:0] gotLut,
                             input logic [DW-1:0] reqCdf, input logic [AW-1:0] reqLut);
    check(gotCdf === reqCdf && gotLut === reqLut,
          $sformatf("%s final: cdf=%0d lut=%0d required cdf=%0d lut=%0d", tag, gotCdf, gotLut, reqCdf, reqLut));
  endtask

  task automatic test_reset();
    iRst   = 1'b1;
    iStart = 1'b0;
    for (int k = 0; k < NB; k++) histo[k] = '0;
    repeat (3) @(negedge iClk);
    check_all_zero("reset");
    iStart = 1'b1;
    @(negedge iClk);
    check_all_zero("reset_start_ignored");
    iStart = 1'b0;
    iRst   = 1'b0;
    repeat (2) @(negedge iClk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_uniform();
    logic [DW-1:0] c;
    logic [AW-1:0] l;
    for (int k = 0; k < NB; k++) histo[k] = DW'(1200);
    run_readout("uniform", -1, -1, -1, c, l);
    check_final("uniform", c, l, DW'(307200), AW'(254));
  endtask

  task automatic test_spike();
    logic [DW-1:0] c;
    logic [AW-1:0] l;
    for (int k = 0; k < NB; k++) histo[k] = '0;
    histo[100] = DW'(307200);
    run_readout("spike", -1, -1, -1, c, l);
    check_final("spike", c, l, DW'(307200), AW'(254));
  endtask

  task automatic test_saturation();
    logic [DW-1:0] c;
    logic [AW-1:0] l;
    for (int k = 0; k < NB; k++) histo[k] = DW'($urandom_range(0, 50));
    histo[0] = '1;
    histo[1] = '1;
    run_readout("saturation", -1, -1, -1, c, l);
    check_final("saturation", c, l, DW'(1048575), AW'(255));
  endtask

  task automatic test_random();
    logic [DW-1:0] c;
    logic [AW-1:0] l;
    for (int k = 0; k < NB; k++) histo[k] = DW'($urandom_range(0, 2400));
    run_readout("random_small", -1, -1, -1, c, l);
    for (int k = 0; k < NB; k++) histo[k] = DW'($urandom_range(0, 16000));
    run_readout("random_large", -1, -1, -1, c, l);
  endtask

  task automatic test_start_ignored();
    logic [DW-1:0] c;
    logic [AW-1:0] l;
    for (int k = 0; k < NB; k++) histo[k] = DW'($urandom_range(0, 3000));
    run_readout("start_ignored", 40, 300, DONE_CYC, c, l);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] c;
    logic [AW-1:0] l;
    bit            found = 0;
    for (int k = 0; k < NB; k++) histo[k] = DW'($urandom_range(1, 2000));
    @(negedge iClk);
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      @(negedge iClk);
      if (oValid === 1'b1 && oBin === AW'(40)) found = 1;
    end
    check(found, "reset_mid reach_bin40: got no bin 40 within 100 cycles, required bin 40");
    iRst = 1'b1;
    #1;
    check_all_zero("reset_mid_async");
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    for (int k = 0; k < NB; k++) histo[k] = DW'($urandom_range(0, 2400));
    run_readout("after_reset", -1, -1, -1, c, l);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_uniform();
    test_spike();
    test_saturation();
    test_random();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/histo_cdf_reader.md
Name: histo_cdf_reader

Overview:
- Read-side companion to the gray-level histogram accumulator.
- On iStart, sweeps every bin through the histogram read port (address on oGray, count on iGrayHisto).
- Streams the bin count, the running cumulative distribution (CDF) and an equalisation LUT value per bin to the downstream LUT writer.
- Then drives oClear for one full address sweep so the histogram is zeroed before the next frame. Asserts oBusy so upstream holds iInc low throughout.

Parameters:
- DATA_WIDTH, 20, width of a histogram bin count and of the CDF.
- ADDR_WIDTH, 8, gray-level width; number of bins NBINS = 2**ADDR_WIDTH.
- RD_LATENCY, 2, cycles from oGray presented to matching iGrayHisto valid.
- SCALE_MUL, 870, LUT scale multiplier (equals (NBINS-1)*2**SCALE_SHIFT/pixels per frame; 640x480 default).
- SCALE_WIDTH, 10, width of SCALE_MUL.
- SCALE_SHIFT, 20, right shift applied to CDF*SCALE_MUL.

Ports:
- iClk  in  1  clock
- iRst  in  1  asynchronous active-high reset
- iStart  in  1  one-cycle pulse; starts a readout when idle, ignored otherwise
- oGray  out  ADDR_WIDTH  histogram read address
- iGrayHisto  in  DATA_WIDTH  histogram count for the address presented RD_LATENCY cycles earlier
- oClear  out  1  histogram clear strobe; one address cleared per cycle while high
- oBusy  out  1  high from accepted iStart until oDone
- oValid  out  1  bin result valid
- oBin  out  ADDR_WIDTH  bin index of the current result
- oCount  out  DATA_WIDTH  raw bin count
- oCdf  out  DATA_WIDTH  cumulative count of bins 0..oBin
- oLut  out  ADDR_WIDTH  equalised gray level for oBin
- oDone  out  1  one-cycle pulse when the clear sweep completes

Behaviour:
- Reset: state IDLE. All outputs 0: oGray, oClear, oBusy, oValid, oBin, oCount, oCdf, oLut, oDone. Address counter, CDF accumulator and latency pipe all cleared.
- States and transitions:
  - IDLE: iStart -> READ. oBusy rises the cycle after iStart.
  - READ: oGray = 0, 1, ... NBINS-1, one address per cycle, NBINS cycles. After the last address -> DRAIN.
  - DRAIN: waits RD_LATENCY+1 cycles so the final result emerges -> CLEAR.
  - CLEAR: oClear high for exactly NBINS cycles, oGray held 0 -> DONE.
  - DONE: oDone=1 and oBusy=0 for one cycle -> IDLE.
- Result alignment: address k issued in cycle t gives oValid=1 in cycle t+RD_LATENCY+1, with:
  - oBin=k
  - oCount=iGrayHisto sampled at t+RD_LATENCY
  - oCdf = sum of counts for bins 0..k
  - oLut computed from that same oCdf value
- oValid is high for exactly NBINS consecutive cycles per readout, bins in ascending order with no gaps.
- Address validity is carried by a RD_LATENCY-deep valid/index shift pipe, not by state decode.
- CDF accumulator is cleared on entry to READ and saturates at 2**DATA_WIDTH-1 (no wrap).
- LUT: p = oCdf*SCALE_MUL, computed at DATA_WIDTH+SCALE_WIDTH bits; oLut = min(p>>SCALE_SHIFT, NBINS-1). Unsigned throughout.
- oCount, oCdf, oLut and oBin hold their last values when oValid=0.
- iStart while oBusy or in DONE: ignored, with no restart and no queueing.
- Reset mid-operation: returns to IDLE immediately; oClear drops asynchronously. The histogram is then partially cleared, and that is acceptable; software re-arms.
- oClear and the READ addressing never overlap.

Decomposition:
- Shared package holds:
  - state enum IDLE/READ/DRAIN/CLEAR/DONE
  - NBINS derived constant
  - default SCALE_MUL/SCALE_SHIFT for 640x480
  - saturating-add width helper
- One natural sub-module: histo_lut_scale. It is a registered multiply-shift-clamp, with combinational output timing matched by the parent.

Test Plan:
- Uniform histogram, every bin=1200 (307200 px): after iStart, 256 consecutive oValid. Bin 0 gives oCdf=1200, oLut=(1200*870)>>20=0. Bin 255 gives oCdf=307200, oLut=254. oClear then high 256 cycles, then a one-cycle oDone.
- Single spike, bin 100=307200 and all others 0: bins 0..99 give oCdf=0, oLut=0. Bins 100..255 give oCdf=307200, oLut=254. oCount=307200 only at oBin=100.
- Latency check: oGray=5 issued at cycle t gives oValid with oBin=5 at t+3 (RD_LATENCY=2); first oValid exactly 3 cycles after oGray=0.
- Saturation: bins 0 and 1 each 2**20-1. oCdf=1048575 at bin 0 and stays 1048575 for all later bins; oLut clamps to 255.
- iStart pulsed during READ and during CLEAR: no restart, exactly 256 oValid and 256 oClear cycles, one oDone.
- iRst asserted at bin 40 of READ: all outputs 0 asynchronously. A new iStart then gives a full 256-bin sweep with oCdf restarting from bin 0.
